// File: rtl/ov5640_init_seq_ctrl.sv
// OV5640 init-table sequencer: walks the register ROM and issues one SCCB write per entry,
// with power-up and soft-reset settle delays. `define OV5640_INIT_RETRY_EN adds NACK retries.
module ov5640_init_seq_ctrl #(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          INIT_NUM     = 91,
  parameter logic [23:0] PWRUP_CYCLES = 24'd480000,
  parameter logic [23:0] SWRST_CYCLES = 24'd120000
`ifdef OV5640_INIT_RETRY_EN
  , parameter int        MAX_RETRY    = 3
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [15:0]           wr_reg_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_done,
  input  logic                  wr_nack,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_error,
  output logic [ADDR_WIDTH-1:0] err_index
);

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, FETCH, LATCH, REQ, WAIT_DONE, SW_DLY, NEXT, DONE, ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INIT_NUM - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, rom_addr_q, rom_addr_d, err_index_q, err_index_d;
  logic [23:0]           cnt_q, cnt_d, cnt_tgt;
  logic [15:0]           wr_reg_addr_q, wr_reg_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  wr_valid_q, wr_valid_d, busy_q, busy_d;
  logic                  init_done_q, init_done_d, init_error_q, init_error_d;
  logic                  cnt_hit, is_swrst, can_start, retry_ok;

  assign can_start = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign cnt_tgt   = (state_q == SW_DLY) ? SWRST_CYCLES : PWRUP_CYCLES;
  // a zero target still spends one cycle in the delay state
  assign cnt_hit   = ({1'b0, cnt_q} + 25'd1) >= {1'b0, cnt_tgt};
  assign is_swrst  = (wr_reg_addr_q == 16'h3008) && wr_data_q[7];

`ifdef OV5640_INIT_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;

  assign retry_ok = retry_q < MAX_R;

  always_comb begin
    retry_d = retry_q;
    if (state_q == WAIT_DONE && wr_done) retry_d = wr_nack ? retry_q + 1'b1 : '0;
    if (can_start) retry_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) retry_q <= '0;
    else     retry_q <= retry_d;
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rom_addr_d    = rom_addr_q;
    err_index_d   = err_index_q;
    cnt_d         = '0;
    wr_reg_addr_d = wr_reg_addr_q;
    wr_data_d     = wr_data_q;
    wr_valid_d    = wr_valid_q;
    busy_d        = busy_q;
    init_done_d   = init_done_q;
    init_error_d  = init_error_q;
    unique case (state_q)
      IDLE, DONE, ERROR: if (can_start) begin
        state_d      = PWR_WAIT;
        busy_d       = 1'b1;
        init_done_d  = 1'b0;
        init_error_d = 1'b0;
        idx_d        = '0;
        rom_addr_d   = '0;
      end
      PWR_WAIT, SW_DLY: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 24'd1;
        if (cnt_hit) state_d = (state_q == PWR_WAIT) ? FETCH : NEXT;
      end
      FETCH: begin
        rom_addr_d = idx_q;
        state_d    = LATCH;
      end
      LATCH: begin
        wr_reg_addr_d = rom_q[23:8];
        wr_data_d     = rom_q[7:0];
        wr_valid_d    = 1'b1;
        state_d       = REQ;
      end
      REQ: if (wr_ready) begin
        wr_valid_d = 1'b0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: if (wr_done) begin
        if (!wr_nack) begin
          state_d = is_swrst ? SW_DLY : NEXT;
        end else if (retry_ok) begin
          wr_valid_d = 1'b1;
          state_d    = REQ;
        end else begin
          state_d      = ERROR;
          init_error_d = 1'b1;
          err_index_d  = idx_q;
          busy_d       = 1'b0;
        end
      end
      NEXT: if (idx_q == LAST_IDX) begin
        state_d     = DONE;
        init_done_d = 1'b1;
        busy_d      = 1'b0;
      end else begin
        // ROM address advances with idx so the registered read is ready by LATCH
        idx_d      = idx_q + 1'b1;
        rom_addr_d = idx_q + 1'b1;
        state_d    = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      rom_addr_q    <= '0;
      err_index_q   <= '0;
      cnt_q         <= '0;
      wr_reg_addr_q <= '0;
      wr_data_q     <= '0;
      wr_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      init_done_q   <= 1'b0;
      init_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rom_addr_q    <= rom_addr_d;
      err_index_q   <= err_index_d;
      cnt_q         <= cnt_d;
      wr_reg_addr_q <= wr_reg_addr_d;
      wr_data_q     <= wr_data_d;
      wr_valid_q    <= wr_valid_d;
      busy_q        <= busy_d;
      init_done_q   <= init_done_d;
      init_error_q  <= init_error_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign wr_valid    = wr_valid_q;
  assign wr_reg_addr = wr_reg_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign init_done   = init_done_q;
  assign init_error  = init_error_q;
  assign err_index   = err_index_q;

endmodule

// File: tb/tb_ov5640_init_seq_ctrl.sv
// Directed bench for ov5640_init_seq_ctrl: ROM table model plus an SCCB master model
// that acks (or NACKs a chosen register) three cycles after each accepted write.
module tb_ov5640_init_seq_ctrl;
  localparam int AW = 8;
  localparam int N  = 91;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, wr_ready = 1'b1, stray_done = 1'b0;
  logic [AW-1:0] rom_addr, err_index;
  logic [23:0]   rom_q = '0;
  logic          wr_valid, wr_done, wr_nack, busy, init_done, init_error;
  logic [15:0]   wr_reg_addr;
  logic [7:0]    wr_data;
  logic          m_done = 1'b0, m_nack = 1'b0, pend_nack = 1'b0;

  int total = 0, bad = 0;

  ov5640_init_seq_ctrl #(.ADDR_WIDTH(AW), .INIT_NUM(N), .PWRUP_CYCLES(24'd10),
                         .SWRST_CYCLES(24'd5)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_reg_addr(wr_reg_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_nack(wr_nack), .busy(busy), .init_done(init_done),
    .init_error(init_error), .err_index(err_index));

  always #5 clk = ~clk;

  function automatic logic [23:0] tbl(input int i);
    if (i == 0) return {16'h3008, 8'h82};
    return {16'h4000 + 16'(i), 8'(i * 3 + 1)};
  endfunction

  always @(posedge clk) rom_q <= tbl(int'(rom_addr));

  // SCCB master model: log every accepted write, answer 3 cycles later
  logic [15:0] log_a[$];
  logic [7:0]  log_d[$];
  int          acc_t[$];
  int          cyc = 0, pend = 0, m_att = 0;
  logic [15:0] nack_addr = 16'hffff;
  int          nack_times = 0, nack_base = 0;

  assign wr_done = m_done | stray_done;
  assign wr_nack = m_nack;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    m_done <= 1'b0;
    m_nack <= 1'b0;
    if (rst) pend <= 0;
    else if (wr_valid && wr_ready) begin
      m_att = 0;
      for (int k = nack_base; k < log_a.size(); k++) if (log_a[k] == nack_addr) m_att++;
      pend_nack <= (wr_reg_addr == nack_addr) && (m_att < nack_times);
      log_a.push_back(wr_reg_addr);
      log_d.push_back(wr_data);
      acc_t.push_back(cyc);
      pend <= 3;
    end else if (pend > 1) pend <= pend - 1;
    else if (pend == 1) begin
      pend   <= 0;
      m_done <= 1'b1;
      m_nack <= pend_nack;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(output bit ok, output bit prev_busy);
    int n = 0;
    prev_busy = busy;
    while (!(init_done || init_error) && n < 5000) begin
      prev_busy = busy;
      @(negedge clk);
      n++;
    end
    ok = init_done || init_error;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!wr_valid && n < 200) begin @(negedge clk); n++; end
  endtask

  function automatic int first_bad(input int base);
    logic [23:0] e;
    for (int i = 0; i < N; i++) begin
      if (base + i >= log_a.size()) return i;
      e = tbl(i);
      if (log_a[base + i] !== e[23:8] || log_d[base + i] !== e[7:0]) return i;
    end
    return -1;
  endfunction

  function automatic int count_addr(input int base, input logic [15:0] a);
    int c = 0;
    for (int k = base; k < log_a.size(); k++) if (log_a[k] == a) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({rom_addr, wr_valid, wr_reg_addr, wr_data, busy, init_done, init_error, err_index} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {rom_addr, wr_valid, wr_reg_addr, wr_data, busy, init_done, init_error, err_index});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({wr_valid, busy, init_done, init_error} !== 4'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b want=0000", {wr_valid, busy, init_done, init_error});
    end
  endtask

  task automatic test_nominal();
    int base = log_a.size(), n, fb, t;
    bit ok, pb;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_on_start got=%b want=1", busy); end
    wait_valid(n);
    total++;
    if (n != 12) begin bad++; $display("FAIL pwrup_latency got=%0d want=12", n); end
    total++;
    if ({wr_reg_addr, wr_data} !== 24'h300882) begin
      bad++; $display("FAIL first_payload got=%h want=300882", {wr_reg_addr, wr_data});
    end
    wait_end(ok, pb);
    t = cyc;
    total++;
    if (!ok) begin bad++; $display("FAIL nominal_timeout got=busy want=done"); end
    total++;
    if ({init_done, init_error, busy, pb} !== 4'b1001) begin
      bad++; $display("FAIL done_flags got=%b want=1001 (done,err,busy,prev_busy)", {init_done, init_error, busy, pb});
    end
    total++;
    if (log_a.size() - base != N) begin bad++; $display("FAIL write_count got=%0d want=%0d", log_a.size() - base, N); end
    fb = first_bad(base);
    total++;
    if (fb != -1) begin bad++; $display("FAIL write_order got=first_bad_index_%0d want=none", fb); end
    if (log_a.size() - base >= 3) begin
      total++;
      if (acc_t[base + 1] - acc_t[base] != 13) begin
        bad++; $display("FAIL swrst_gap got=%0d want=13", acc_t[base + 1] - acc_t[base]);
      end
      total++;
      if (acc_t[base + 2] - acc_t[base + 1] != 8) begin
        bad++; $display("FAIL entry_gap got=%0d want=8", acc_t[base + 2] - acc_t[base + 1]);
      end
      total++;
      if (t - acc_t[log_a.size() - 1] != 6) begin
        bad++; $display("FAIL done_latency got=%0d want=6", t - acc_t[log_a.size() - 1]);
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if ({init_done, busy} !== 2'b10) begin bad++; $display("FAIL done_sticky got=%b want=10", {init_done, busy}); end
  endtask

  task automatic test_backpressure();
    int base = log_a.size(), n, unstable = 0;
    bit ok, pb;
    wr_ready = 1'b0;
    pulse_start();
    wait_valid(n);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if ({wr_valid, wr_reg_addr, wr_data} !== 25'h1300882) unstable++;
    end
    total++;
    if (unstable != 0 || n >= 200) begin bad++; $display("FAIL bp_stable got=%0d_bad_samples want=0", unstable); end
    total++;
    if (log_a.size() != base) begin bad++; $display("FAIL bp_no_accept got=%0d want=0", log_a.size() - base); end
    wr_ready = 1'b1;
    @(negedge clk);
    total++;
    if (wr_valid !== 1'b0 || log_a.size() - base != 1) begin
      bad++; $display("FAIL bp_single got=valid_%b_writes_%0d want=valid_0_writes_1", wr_valid, log_a.size() - base);
    end
    wait_end(ok, pb);
    total++;
    if (!ok || !init_done || log_a.size() - base != N) begin
      bad++; $display("FAIL bp_count got=%0d want=%0d", log_a.size() - base, N);
    end
  endtask

  task automatic test_nack();
    int base = log_a.size(), att, quiet = 0, base2;
    bit ok, pb;
`ifdef OV5640_INIT_RETRY_EN
    int want_att = 4;
`else
    int want_att = 1;
`endif
    nack_base = base; nack_addr = 16'h4005; nack_times = 1000;
    pulse_start();
    wait_end(ok, pb);
    total++;
    if ({ok, init_error, init_done, busy} !== 4'b1100) begin
      bad++; $display("FAIL nack_flags got=%b want=1100 (ok,err,done,busy)", {ok, init_error, init_done, busy});
    end
    total++;
    if (err_index !== 8'd5) begin bad++; $display("FAIL nack_err_index got=%0d want=5", err_index); end
    att = count_addr(base, 16'h4005);
    total++;
    if (att != want_att || log_a.size() - base != 5 + want_att) begin
      bad++; $display("FAIL nack_attempts got=%0d_of_%0d want=%0d_of_%0d", att, log_a.size() - base, want_att, 5 + want_att);
    end
    repeat (20) begin @(negedge clk); if (wr_valid) quiet++; end
    total++;
    if (quiet != 0 || init_error !== 1'b1) begin
      bad++; $display("FAIL nack_quiet got=valid_cycles_%0d_err_%b want=0_1", quiet, init_error);
    end
    nack_times = 0;
    base2 = log_a.size();
    pulse_start();
    total++;
    if ({init_error, busy} !== 2'b01) begin bad++; $display("FAIL restart_clear got=%b want=01", {init_error, busy}); end
    wait_end(ok, pb);
    total++;
    if (!init_done || first_bad(base2) != -1 || log_a.size() - base2 != N) begin
      bad++; $display("FAIL restart_run got=done_%b_writes_%0d want=done_1_writes_%0d", init_done, log_a.size() - base2, N);
    end
  endtask

`ifdef OV5640_INIT_RETRY_EN
  task automatic test_retry();
    int base = log_a.size();
    bit ok, pb;
    nack_base = base; nack_addr = 16'h4005; nack_times = 2;
    pulse_start();
    wait_end(ok, pb);
    nack_times = 0;
    total++;
    if ({init_done, init_error} !== 2'b10) begin bad++; $display("FAIL retry_done got=%b want=10", {init_done, init_error}); end
    total++;
    if (count_addr(base, 16'h4005) != 3 || log_a.size() - base != N + 2) begin
      bad++; $display("FAIL retry_writes got=%0d_idx5_%0d_total want=3_%0d", count_addr(base, 16'h4005), log_a.size() - base, N + 2);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int base = log_a.size(), n = 0, base2;
    bit ok, pb;
    pulse_start();
    while (log_a.size() - base < 41 && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (log_a.size() - base != 41) begin bad++; $display("FAIL rstmid_reach got=%0d want=41", log_a.size() - base); end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    stray_done = 1'b1;
    @(negedge clk) stray_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({rom_addr, wr_valid, wr_reg_addr, wr_data, busy, init_done, init_error, err_index} !== '0
        || log_a.size() - base != 41) begin
      bad++; $display("FAIL rstmid_idle got=%h_writes_%0d want=0_41",
        {rom_addr, wr_valid, wr_reg_addr, wr_data, busy, init_done, init_error, err_index}, log_a.size() - base);
    end
    base2 = log_a.size();
    pulse_start();
    wait_valid(n);
    total++;
    if (n != 12 || {wr_reg_addr, wr_data} !== 24'h300882) begin
      bad++; $display("FAIL rstmid_restart got=lat_%0d_%h want=lat_12_300882", n, {wr_reg_addr, wr_data});
    end
    wait_end(ok, pb);
    total++;
    if (!init_done || log_a.size() - base2 != N || first_bad(base2) != -1) begin
      bad++; $display("FAIL rstmid_run got=%0d want=%0d", log_a.size() - base2, N);
    end
  endtask

  task automatic test_start_busy();
    int base = log_a.size(), n = 0;
    bit ok, pb;
    pulse_start();
    while (!wr_valid && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == 3 || n == 7);
    end
    start = 1'b0;
    total++;
    if (n != 12) begin bad++; $display("FAIL start_in_pwrwait got=lat_%0d want=12", n); end
    n = 0;
    while (log_a.size() - base < 20 && n < 2000) begin @(negedge clk); n++; end
    pulse_start();
    wait_end(ok, pb);
    total++;
    if (!init_done || log_a.size() - base != N || first_bad(base) != -1) begin
      bad++; $display("FAIL start_busy_count got=%0d want=%0d", log_a.size() - base, N);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_nack();
`ifdef OV5640_INIT_RETRY_EN
    test_retry();
`endif
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
